// File: rtl/rnn_input_feeder.sv
// rnn_input_feeder: input-side vector FIFO and launcher for the RNN core.
// Host vectors arrive over a valid/ready stream and are buffered. Once
// enough are buffered and the core is idle, a launch request ('ready')
// is raised. Each 'i_en' from the core pops the next vector into 'idata'.
// Optional feature macro: RNN_FEED_CNT_EN adds the 16-bit 'feed_cnt' port.
module rnn_input_feeder #(
  parameter int DEPTH       = 16,
  parameter int START_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [31:0]                s_data,
  input  logic                       busy,
  input  logic                       i_en,
  output logic                       ready,
  output logic [31:0]                idata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underflow
`ifdef RNN_FEED_CNT_EN
  ,
  output logic [15:0]                feed_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_ready;
  logic [31:0]     r_idata;
  logic            r_underflow;
  logic [LW-1:0]   r_level;
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [31:0]     r_mem [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_active;
  logic            w_empty;
  logic            w_full;

  // Handshake and pop qualification; a pop never reads through an
  // empty FIFO, so a same-cycle push cannot bypass into idata.
  always_comb begin
    w_full   = (r_level == LW'(DEPTH));
    w_empty  = (r_level == '0);
    w_active = (r_state == ARM) || (r_state == RUN);
    w_push   = s_valid && !w_full;
    w_pop    = i_en && w_active && !w_empty;
  end

  assign s_ready   = !w_full;
  assign ready     = r_ready;
  assign idata     = r_idata;
  assign level     = r_level;
  assign underflow = r_underflow;

  // Storage array; stale contents are harmless because pointers reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= s_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Output vector register and sticky underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idata     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_idata <= r_mem[r_rdPtr];
      end
      if (i_en && w_active && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Launch FSM with registered ready; RUN always returns through IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((r_level >= LW'(START_LEVEL)) && !busy) begin
            r_state <= ARM;
            r_ready <= 1'b1;
          end
        end
        ARM: begin
          if (busy) begin
            r_state <= RUN;
            r_ready <= 1'b0;
          end
        end
        RUN: begin
          r_ready <= 1'b0;
          if (!busy) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef RNN_FEED_CNT_EN
  logic [15:0] r_feedCnt;

  // Count of vectors actually delivered; wraps at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_feedCnt <= '0;
    end else if (w_pop) begin
      r_feedCnt <= r_feedCnt + 16'd1;
    end
  end

  assign feed_cnt = r_feedCnt;
`endif

endmodule

// File: tb/tb_rnn_input_feeder.sv
// Testbench for rnn_input_feeder: directed stimulus, a queue-based
// reference model compared every cycle, plus literal spot checks.
module tb_rnn_input_feeder;

  localparam int DEPTH       = 16;
  localparam int START_LEVEL = 1;
  localparam int LW          = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          busy = 1'b0;
  logic          i_en = 1'b0;
  logic          ready;
  logic [31:0]   idata;
  logic [LW-1:0] level;
  logic          underflow;
`ifdef RNN_FEED_CNT_EN
  logic [15:0]   feed_cnt;
`endif

  int vectorCount = 0;
  int missCount   = 0;

  rnn_input_feeder #(
    .DEPTH(DEPTH),
    .START_LEVEL(START_LEVEL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .busy(busy),
    .i_en(i_en),
    .ready(ready),
    .idata(idata),
    .level(level),
    .underflow(underflow)
`ifdef RNN_FEED_CNT_EN
    ,
    .feed_cnt(feed_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of buffered vectors and a launch phase.
  typedef enum int { P_IDLE, P_ARM, P_RUN } phase_t;
  logic [31:0] mq [$];
  phase_t      mPhase;
  logic [31:0] mIdata;
  logic        mUnder;
  logic [15:0] mFeed;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mPhase = P_IDLE;
      mIdata = '0;
      mUnder = 1'b0;
      mFeed  = '0;
    end else begin
      int  preSize;
      bit  canConsume;
      preSize    = mq.size();
      canConsume = (mPhase != P_IDLE);
      if (i_en && canConsume) begin
        if (preSize > 0) begin
          mIdata = mq.pop_front();
          mFeed  = mFeed + 16'd1;
        end else begin
          mUnder = 1'b1;
        end
      end
      if (s_valid && preSize < DEPTH) mq.push_back(s_data);
      case (mPhase)
        P_IDLE:  if (preSize >= START_LEVEL && !busy) mPhase = P_ARM;
        P_ARM:   if (busy) mPhase = P_RUN;
        default: if (!busy) mPhase = P_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("model.level", 32'(level), 32'(mq.size()));
    checkOutput("model.s_ready", 32'(s_ready), 32'(mq.size() != DEPTH));
    checkOutput("model.ready", 32'(ready), 32'(mPhase == P_ARM));
    checkOutput("model.idata", idata, mIdata);
    checkOutput("model.underflow", 32'(underflow), 32'(mUnder));
`ifdef RNN_FEED_CNT_EN
    checkOutput("model.feed_cnt", 32'(feed_cnt), 32'(mFeed));
`endif
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    // Reset with s_valid held high: nothing may be stored.
    s_valid = 1'b1;
    s_data  = 32'hCAFE0000;
    applyStimulus(3);
    checkOutput("rst.ready", 32'(ready), 32'd0);
    checkOutput("rst.idata", idata, 32'd0);
    checkOutput("rst.level", 32'(level), 32'd0);
    checkOutput("rst.underflow", 32'(underflow), 32'd0);
    reset   = 1'b0;
    s_valid = 1'b0;
    #1;
    checkOutput("rst.s_ready", 32'(s_ready), 32'd1);
    applyStimulus(1);

    // Launch.
    s_valid = 1'b1;
    s_data  = 32'h000000A5;
    applyStimulus(1);
    s_valid = 1'b0;
    checkOutput("launch.level", 32'(level), 32'd1);
    checkOutput("launch.ready_early", 32'(ready), 32'd0);
    applyStimulus(1);
    checkOutput("launch.ready", 32'(ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput("launch.ready_hold", 32'(ready), 32'd1);
    end
    busy = 1'b1;
    applyStimulus(1);
    checkOutput("launch.ready_drop", 32'(ready), 32'd0);
    i_en = 1'b1;
    applyStimulus(1);
    i_en = 1'b0;
    checkOutput("launch.idata", idata, 32'h000000A5);

    // Ordering.
    s_valid = 1'b1;
    s_data = 32'h11111111; applyStimulus(1);
    s_data = 32'h22222222; applyStimulus(1);
    s_data = 32'h33333333; applyStimulus(1);
    s_valid = 1'b0;
    checkOutput("order.level3", 32'(level), 32'd3);
    i_en = 1'b1;
    applyStimulus(1);
    checkOutput("order.idata1", idata, 32'h11111111);
    applyStimulus(1);
    checkOutput("order.idata2", idata, 32'h22222222);
    applyStimulus(1);
    checkOutput("order.idata3", idata, 32'h33333333);
    checkOutput("order.level0", 32'(level), 32'd0);

    // Underflow, then a same-cycle push that must not bypass.
    applyStimulus(1);
    i_en = 1'b0;
    checkOutput("uf.idata", idata, 32'h33333333);
    checkOutput("uf.flag", 32'(underflow), 32'd1);
    s_valid = 1'b1;
    s_data  = 32'h55555555;
    i_en    = 1'b1;
    applyStimulus(1);
    s_valid = 1'b0;
    i_en    = 1'b0;
    checkOutput("uf.nobypass", idata, 32'h33333333);
    checkOutput("uf.level", 32'(level), 32'd1);
    i_en = 1'b1;
    applyStimulus(1);
    i_en = 1'b0;
    checkOutput("uf.pop", idata, 32'h55555555);
    checkOutput("uf.sticky", 32'(underflow), 32'd1);

    // Back to IDLE; foreign busy blocks launch; i_en ignored in IDLE.
    busy = 1'b0;
    applyStimulus(1);
    busy    = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h66666666;
    applyStimulus(1);
    s_valid = 1'b0;
    i_en    = 1'b1;
    applyStimulus(1);
    i_en = 1'b0;
    checkOutput("idle.level", 32'(level), 32'd1);
    checkOutput("idle.idata", idata, 32'h55555555);
    applyStimulus(1);
    checkOutput("idle.blocked", 32'(ready), 32'd0);
    busy = 1'b0;
    applyStimulus(1);
    checkOutput("idle.arm", 32'(ready), 32'd1);
    busy = 1'b1;
    i_en = 1'b1;
    applyStimulus(1);
    i_en = 1'b0;
    checkOutput("arm.pop", idata, 32'h66666666);

    // Full FIFO.
    s_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      s_data = 32'h00001000 + 32'(i);
      applyStimulus(1);
    end
    checkOutput("full.level", 32'(level), 32'(DEPTH));
    checkOutput("full.s_ready", 32'(s_ready), 32'd0);
    s_data = 32'hDEADBEEF;
    applyStimulus(1);
    checkOutput("full.reject", 32'(level), 32'(DEPTH));
    i_en = 1'b1;
    applyStimulus(1);
    s_valid = 1'b0;
    checkOutput("full.pop_level", 32'(level), 32'(DEPTH - 1));
    checkOutput("full.pop_s_ready", 32'(s_ready), 32'd1);
    checkOutput("full.pop_idata", idata, 32'h00001000);
    applyStimulus(13);
    i_en = 1'b0;
    checkOutput("wrap.idata", idata, 32'h0000100D);
    checkOutput("wrap.level", 32'(level), 32'd2);

    // RUN -> IDLE takes a cycle before relaunching.
    busy = 1'b0;
    applyStimulus(1);
    checkOutput("relaunch.gap", 32'(ready), 32'd0);
    applyStimulus(1);
    checkOutput("relaunch.arm", 32'(ready), 32'd1);

    // Asynchronous reset mid-operation.
    reset = 1'b1;
    #1;
    checkOutput("midrst.level", 32'(level), 32'd0);
    checkOutput("midrst.ready", 32'(ready), 32'd0);
    checkOutput("midrst.idata", idata, 32'd0);
    checkOutput("midrst.underflow", 32'(underflow), 32'd0);
    checkOutput("midrst.s_ready", 32'(s_ready), 32'd1);
    applyStimulus(1);
    reset = 1'b0;

    // Delivery counting: three pops and one underflowed request.
    s_valid = 1'b1;
    s_data = 32'h77777777; applyStimulus(1);
    s_data = 32'h88888888; applyStimulus(1);
    s_data = 32'h99999999; applyStimulus(1);
    s_valid = 1'b0;
    busy = 1'b1;
    applyStimulus(1);
    i_en = 1'b1;
    applyStimulus(4);
    i_en = 1'b0;
    checkOutput("cnt.idata", idata, 32'h99999999);
    checkOutput("cnt.underflow", 32'(underflow), 32'd1);
`ifdef RNN_FEED_CNT_EN
    checkOutput("cnt.feed_cnt", 32'(feed_cnt), 32'd3);
`endif
    busy = 1'b0;
    applyStimulus(1);
    reset = 1'b1;
    applyStimulus(1);
`ifdef RNN_FEED_CNT_EN
    checkOutput("cnt.reset", 32'(feed_cnt), 32'd0);
`endif
    reset = 1'b0;
    applyStimulus(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/rnn_input_feeder.md
# rnn_input_feeder

Input-side buffer and launcher for the RNN core. Accepts 32-bit input vectors from the host over a valid/ready stream and holds them in a FIFO. It pulses the core's `ready` start request once enough vectors are buffered. On every `i_en` request from the core, it presents the next vector on `idata` in the following cycle.

## Interface
Parameters:
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `START_LEVEL`, 1, minimum buffered vectors before a run is launched; 1..DEPTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  host vector valid.
- `s_ready`  out  1  FIFO can accept; equals `!full`.
- `s_data`  in  32  host input vector (bit k = input element k).
- `busy`  in  1  core busy, from RNN core.
- `i_en`  in  1  core request for the next vector.
- `ready`  out  1  launch request to the core.
- `idata`  out  32  vector presented to the core.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `underflow`  out  1  sticky error: `i_en` seen with FIFO empty.
- `feed_cnt`  out  16  vectors delivered to the core; present only with `RNN_FEED_CNT_EN`.

## Operation
- FIFO:
  - Push when `s_valid && s_ready`.
  - Pop when `i_en` is high, the FSM is in ARM or RUN, and the FIFO is not empty.
  - Simultaneous push and pop leave `level` unchanged.
  - Pointers wrap modulo DEPTH.
  - `s_ready` is combinational `level != DEPTH`, so there is no push while full, even with a same-cycle pop.
- `idata` is a register:
  - On a pop, it loads the FIFO head at the same edge.
  - Otherwise it holds its value.
- Underflow:
  - `i_en` high in ARM/RUN with the FIFO empty: no pop, `idata` holds, `underflow` sets.
  - `underflow` clears only on reset.
  - A push in that same cycle is not bypassed to `idata`.
- `i_en` in IDLE is ignored: no pop, no flag.
- FSM states: IDLE, ARM, RUN.
  - IDLE → ARM when `level >= START_LEVEL` and `busy == 0`. `ready` is registered high on the same edge.
  - ARM: `ready` stays high. On `busy == 1` → RUN, and `ready` drops on that edge.
  - RUN: `ready` is 0. On `busy == 0` → IDLE.
  - RUN → IDLE does not relaunch in the same edge. IDLE needs at least one cycle before the next ARM.
  - A `busy` already high in IDLE (foreign launch) blocks ARM until it drops.
- Reset mid-operation clears everything immediately:
  - Pointers to 0, `level` to 0, FIFO contents discarded, FSM to IDLE.
  - Outputs: `ready`=0, `idata`=0, `underflow`=0, `feed_cnt`=0.
  - `s_ready` becomes 1 after reset, since the FIFO is empty.

## Timing
- Push-to-launch latency, with `START_LEVEL`=1 and the FIFO previously empty:
  - Push accepted at edge N, so `level`=1 after N.
  - `ready` is high after edge N+1.
- Pop latency: `i_en` sampled high at edge M makes the new `idata` valid after M. The core samples it at M+1.
- Back-to-back `i_en` on consecutive cycles pops consecutive entries.
- `level` and `underflow` are registered. `s_ready` is combinational from `level`.

## Configuration
- `RNN_FEED_CNT_EN` defined:
  - Adds the `feed_cnt` port, a 16-bit counter that increments on each successful pop.
  - Wraps from 0xFFFF to 0.
  - Reset to 0.
- Undefined: no `feed_cnt` port and no counter logic; all other behaviour is identical.

## Test plan
- Reset with `s_valid`=1 asserted → `ready`=0, `idata`=0, `level`=0, `underflow`=0, and no push while reset is high; `s_ready`=1 after release.
- Launch: push 0x0000_00A5 with `busy`=0 → `ready`=1 two edges after the push; hold `busy`=0 for 5 cycles → `ready` stays 1; raise `busy` → `ready`=0 next edge, FSM in RUN.
- Ordering: push 0x11111111, 0x22222222, 0x33333333; pulse `i_en` on three consecutive cycles in RUN → `idata` is 0x11111111, 0x22222222, 0x33333333 on consecutive cycles; `level` goes 3→0.
- Full (`DEPTH`=16): push 16 vectors → `s_ready`=0, `level`=16; assert `s_valid` with 0xDEADBEEF → not stored; one pop → `s_ready`=1, `level`=15.
- Underflow: in RUN with `level`=0, pulse `i_en` → `idata` unchanged, `underflow`=1; then push plus pop → `underflow` stays 1 until reset.
- With `RNN_FEED_CNT_EN`: 3 pops plus 1 underflowed `i_en` → `feed_cnt`=3; reset → 0.
